// File: rtl/change_dispenser.sv
// Coin change dispenser: splits a multiple-of-5 amount into 25/10/5 coin pulses for a hopper.
// Optional CHANGE_DISPENSER_ABORT_EN adds an abort input that cuts a dispense short.
module change_dispenser #(
    parameter int unsigned PULSE_CYCLES = 4,
    parameter int unsigned GAP_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [6:0] amount,
`ifdef CHANGE_DISPENSER_ABORT_EN
    input  logic       abort,
`endif
    output logic       coin_25,
    output logic       coin_10,
    output logic       coin_5,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [6:0] remaining
);

    typedef enum logic [2:0] {IDLE, SELECT, PULSE, GAP, DONE} state_t;

    localparam logic [3:0] PULSE_LAST = 4'(PULSE_CYCLES - 1);
    localparam logic [3:0] GAP_LAST   = 4'(GAP_CYCLES - 1);

    state_t     state;
    logic [3:0] cnt;
    logic       aborted;
    logic       abort_req;
    logic [6:0] coin_val;

`ifdef CHANGE_DISPENSER_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        coin_val = 7'd5;
        if (coin_25)      coin_val = 7'd25;
        else if (coin_10) coin_val = 7'd10;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            remaining <= 7'd0;
            coin_25   <= 1'b0;
            coin_10   <= 1'b0;
            coin_5    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            cnt  <= cnt + 4'd1;
            case (state)
                IDLE: begin
                    cnt <= 4'd0;
                    if (start) begin
                        if (amount % 7'd5 == 7'd0) begin
                            remaining <= amount;
                            busy      <= 1'b1;
                            state     <= SELECT;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SELECT: begin
                    cnt <= 4'd0;
                    // remaining is always a multiple of 5, so the fall-through means zero
                    if (remaining >= 7'd25) begin
                        coin_25 <= 1'b1;
                        state   <= PULSE;
                    end else if (remaining >= 7'd10) begin
                        coin_10 <= 1'b1;
                        state   <= PULSE;
                    end else if (remaining >= 7'd5) begin
                        coin_5 <= 1'b1;
                        state  <= PULSE;
                    end else begin
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                PULSE: begin
                    if (abort_req || cnt == PULSE_LAST) begin
                        coin_25   <= 1'b0;
                        coin_10   <= 1'b0;
                        coin_5    <= 1'b0;
                        remaining <= remaining - coin_val;
                        cnt       <= 4'd0;
                        aborted   <= abort_req;
                        state     <= GAP;
                    end
                end
                GAP: begin
                    if (abort_req) begin
                        cnt     <= 4'd0;
                        aborted <= 1'b1;
                    end else if (cnt == GAP_LAST) begin
                        cnt <= 4'd0;
                        if (aborted) begin
                            aborted <= 1'b0;
                            done    <= 1'b1;
                            state   <= DONE;
                        end else begin
                            state <= SELECT;
                        end
                    end
                end
                DONE: begin
                    cnt   <= 4'd0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    cnt   <= 4'd0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: cycle-exact coin timing, rejection, idle-start, reset and abort.
module tb_change_dispenser;

    logic       clk;
    logic       reset;
    logic       start;
    logic [6:0] amount;
    logic       coin_25, coin_10, coin_5;
    logic       busy, done, err;
    logic [6:0] remaining;
`ifdef CHANGE_DISPENSER_ABORT_EN
    logic       abort;
`endif

    int n_cmp = 0;
    int n_err = 0;

    change_dispenser dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .amount    (amount),
`ifdef CHANGE_DISPENSER_ABORT_EN
        .abort     (abort),
`endif
        .coin_25   (coin_25),
        .coin_10   (coin_10),
        .coin_5    (coin_5),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse counters for the coin and done outputs
    logic clr;
    int   n25, n10, n5, ndone;
    logic p25, p10, p5, pdone;
    always @(posedge clk) begin
        p25   <= coin_25;
        p10   <= coin_10;
        p5    <= coin_5;
        pdone <= done;
        if (clr) begin
            n25 <= 0; n10 <= 0; n5 <= 0; ndone <= 0;
        end else begin
            if (coin_25 && !p25) n25 <= n25 + 1;
            if (coin_10 && !p10) n10 <= n10 + 1;
            if (coin_5 && !p5)   n5  <= n5 + 1;
            if (done && !pdone)  ndone <= ndone + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clear_counts();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        while (done !== 1'b1 && k < 300) begin
            tick();
            k++;
        end
        chk({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        tick();
        tick();
    endtask

    initial begin
        reset  = 1'b0;
        start  = 1'b0;
        amount = 7'd0;
        clr    = 1'b1;
`ifdef CHANGE_DISPENSER_ABORT_EN
        abort  = 1'b0;
`endif
        #2 reset = 1'b1;
        tick();
        tick();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        chk("rst_coins", {29'd0, coin_25, coin_10, coin_5}, 32'd0);
        chk("rst_rem", {25'd0, remaining}, 32'd0);
        reset = 1'b0;
        tick();
        clr = 1'b0;
        tick();

        // amount=40: exact per-cycle schedule, amount input changes while busy
        start  = 1'b1;
        amount = 7'd40;
        tick();
        start  = 1'b0;
        amount = 7'd99;
        for (int c = 1; c <= 30; c++) begin
            chk($sformatf("a40_c25_%0d", c), {31'd0, coin_25}, {31'd0, c >= 2 && c <= 5});
            chk($sformatf("a40_c10_%0d", c), {31'd0, coin_10}, {31'd0, c >= 11 && c <= 14});
            chk($sformatf("a40_c5_%0d", c), {31'd0, coin_5}, {31'd0, c >= 20 && c <= 23});
            chk($sformatf("a40_done_%0d", c), {31'd0, done}, {31'd0, c == 29});
            chk($sformatf("a40_busy_%0d", c), {31'd0, busy}, {31'd0, c <= 29});
            chk($sformatf("a40_rem_%0d", c), {25'd0, remaining},
                (c <= 5) ? 32'd40 : (c <= 14) ? 32'd15 : (c <= 23) ? 32'd5 : 32'd0);
            tick();
        end
        chk("a40_ndone", ndone, 32'd1);

        // amount=125: five quarters only
        clear_counts();
        start  = 1'b1;
        amount = 7'd125;
        tick();
        start = 1'b0;
        wait_done("a125");
        chk("a125_n25", n25, 32'd5);
        chk("a125_n10", n10, 32'd0);
        chk("a125_n5", n5, 32'd0);
        chk("a125_rem", {25'd0, remaining}, 32'd0);
        chk("a125_ndone", ndone, 32'd1);
        chk("a125_busy", {31'd0, busy}, 32'd0);

        // amount=7: rejected
        clear_counts();
        start  = 1'b1;
        amount = 7'd7;
        tick();
        start = 1'b0;
        chk("a7_err", {31'd0, err}, 32'd1);
        chk("a7_busy", {31'd0, busy}, 32'd0);
        chk("a7_rem", {25'd0, remaining}, 32'd0);
        tick();
        chk("a7_err_off", {31'd0, err}, 32'd0);
        chk("a7_busy2", {31'd0, busy}, 32'd0);
        tick();
        chk("a7_coins", n25 + n10 + n5, 32'd0);

        // amount=0: SELECT then DONE directly
        clear_counts();
        start  = 1'b1;
        amount = 7'd0;
        tick();
        start = 1'b0;
        chk("a0_busy1", {31'd0, busy}, 32'd1);
        chk("a0_done1", {31'd0, done}, 32'd0);
        tick();
        chk("a0_done2", {31'd0, done}, 32'd1);
        tick();
        chk("a0_done3", {31'd0, done}, 32'd0);
        chk("a0_busy3", {31'd0, busy}, 32'd0);
        chk("a0_coins", n25 + n10 + n5, 32'd0);

        // amount=30 with a second start mid-dispense
        clear_counts();
        start  = 1'b1;
        amount = 7'd30;
        tick();
        start = 1'b0;
        tick();
        tick();
        start  = 1'b1;
        amount = 7'd10;
        tick();
        start = 1'b0;
        wait_done("a30");
        chk("a30_n25", n25, 32'd1);
        chk("a30_n10", n10, 32'd0);
        chk("a30_n5", n5, 32'd1);
        chk("a30_ndone", ndone, 32'd1);
        chk("a30_rem", {25'd0, remaining}, 32'd0);

        // amount=35 with reset mid quarter pulse
        clear_counts();
        start  = 1'b1;
        amount = 7'd35;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("rs_pre_c25", {31'd0, coin_25}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rs_c25", {31'd0, coin_25}, 32'd0);
        chk("rs_busy", {31'd0, busy}, 32'd0);
        chk("rs_rem", {25'd0, remaining}, 32'd0);
        chk("rs_done", {31'd0, done}, 32'd0);
        #2 reset = 1'b0;
        tick();
        for (int c = 0; c < 12; c++) begin
            chk($sformatf("rs_idle_coins_%0d", c), {29'd0, coin_25, coin_10, coin_5}, 32'd0);
            chk($sformatf("rs_idle_busy_%0d", c), {31'd0, busy}, 32'd0);
            tick();
        end

`ifdef CHANGE_DISPENSER_ABORT_EN
        // amount=35 with abort during the first quarter pulse
        clear_counts();
        start  = 1'b1;
        amount = 7'd35;
        tick();
        start = 1'b0;
        tick();
        chk("ab_c25", {31'd0, coin_25}, 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        for (int c = 3; c <= 8; c++) begin
            chk($sformatf("ab_c25_%0d", c), {31'd0, coin_25}, 32'd0);
            chk($sformatf("ab_done_%0d", c), {31'd0, done}, {31'd0, c == 7});
            chk($sformatf("ab_busy_%0d", c), {31'd0, busy}, {31'd0, c <= 7});
            chk($sformatf("ab_rem_%0d", c), {25'd0, remaining}, 32'd10);
            tick();
        end
        chk("ab_n10", n10, 32'd0);
        chk("ab_n5", n5, 32'd0);
        chk("ab_ndone", ndone, 32'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
